// File: rtl/sigctrl_pkg.sv
// sigctrl_pkg: shared types and constants for multi_dir_signal_ctrl.
//   sig_state_t : controller phase (ALL_RED, GREEN, YELLOW)
//   LAMP_*      : per-direction lamp encodings, packed as {red, yellow, green}
//   max3        : constant function used to size the seconds counter
package sigctrl_pkg;

    typedef enum logic [1:0] {
        ALL_RED = 2'd0,
        GREEN   = 2'd1,
        YELLOW  = 2'd2
    } sig_state_t;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// sec_tick_gen: one-second tick prescaler.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   clr  : synchronous restart of the count (state entry)
//   tick : one-cycle pulse on the last cycle of every TICK_DIV-cycle period
module sec_tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) cnt_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/multi_dir_signal_ctrl.sv
// multi_dir_signal_ctrl: round-robin intersection controller for NUM_DIRS
// approaches with green -> yellow -> all-red sequencing and per-direction
// pedestrian requests.
//   clk, rst  : system clock, asynchronous active-high reset
//   ped_req   : asynchronous pedestrian buttons, one per direction
//   red/yellow/green : registered lamp outputs, one-hot per direction
//   walk      : walk lamp, lit during a green that served a request
//   ped_wait  : blinking indicator for a pending request
//   phase     : index of the direction currently or last served
// Optional feature: define SIGCTRL_PED_PRIORITY_EN to truncate a green to
// MIN_GREEN_S once another direction has a pending pedestrian request.
module multi_dir_signal_ctrl
    import sigctrl_pkg::*;
#(
    parameter int NUM_DIRS    = 4,
    parameter int TICK_DIV    = 50_000_000,
    parameter int GREEN_S     = 10,
    parameter int MIN_GREEN_S = 3,
    parameter int YELLOW_S    = 2,
    parameter int ALL_RED_S   = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_DIRS-1:0]         ped_req,
    output logic [NUM_DIRS-1:0]         red,
    output logic [NUM_DIRS-1:0]         yellow,
    output logic [NUM_DIRS-1:0]         green,
    output logic [NUM_DIRS-1:0]         walk,
    output logic [NUM_DIRS-1:0]         ped_wait,
    output logic [$clog2(NUM_DIRS)-1:0] phase
);

    localparam int CW = $clog2(NUM_DIRS);
    localparam int SW = $clog2(max3(GREEN_S, YELLOW_S, ALL_RED_S) + 1);
    localparam logic [CW-1:0] LAST_DIR = CW'(NUM_DIRS - 1);

`ifdef SIGCTRL_PED_PRIORITY_EN
    localparam logic PRIO_EN = 1'b1;
`else
    localparam logic PRIO_EN = 1'b0;
`endif

    sig_state_t          state_q, state_d;
    logic [CW-1:0]       cur_q, cur_d;
    logic [SW-1:0]       sec_q, sec_d;
    logic                blink_q, blink_d;
    logic [NUM_DIRS-1:0] pending_q, pending_d;
    logic [NUM_DIRS-1:0] walk_latch_q, walk_latch_d;
    logic [NUM_DIRS-1:0] red_q, red_d;
    logic [NUM_DIRS-1:0] yellow_q, yellow_d;
    logic [NUM_DIRS-1:0] green_q, green_d;

    logic                tick;
    logic                leave;
    logic                prio_hit;
    logic [NUM_DIRS-1:0] ped_edge;
    logic [NUM_DIRS-1:0] cur_mask;
    logic [NUM_DIRS-1:0] next_mask;
    logic [NUM_DIRS-1:0] ignore_mask;
    logic [2:0]          lamp_sel;

    sec_tick_gen #(.TICK_DIV(TICK_DIV)) u_sec_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (leave),
        .tick (tick)
    );

    // Two-flop synchroniser followed by a rising-edge detector per button.
    for (genvar g = 0; g < NUM_DIRS; g++) begin : g_ped
        logic meta_q, sync_q, prev_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                meta_q <= 1'b0;
                sync_q <= 1'b0;
                prev_q <= 1'b0;
            end else begin
                meta_q <= ped_req[g];
                sync_q <= meta_q;
                prev_q <= sync_q;
            end
        end
        assign ped_edge[g] = sync_q & ~prev_q;
    end

    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        sec_d        = sec_q;
        blink_d      = blink_q;
        leave        = 1'b0;
        cur_mask     = '0;
        next_mask    = '0;
        red_d        = '0;
        yellow_d     = '0;
        green_d      = '0;
        lamp_sel     = LAMP_RED;

        for (int unsigned d = 0; d < NUM_DIRS; d++) begin
            cur_mask[d] = (CW'(d) == cur_q);
        end

        prio_hit = PRIO_EN && (|(pending_q & ~cur_mask))
                   && (sec_q >= SW'(MIN_GREEN_S - 1));

        if (tick) begin
            sec_d   = sec_q + 1'b1;
            blink_d = ~blink_q;
            case (state_q)
                ALL_RED: leave = (sec_q == SW'(ALL_RED_S - 1));
                GREEN:   leave = (sec_q == SW'(GREEN_S - 1)) || prio_hit;
                YELLOW:  leave = (sec_q == SW'(YELLOW_S - 1));
                default: leave = 1'b1;
            endcase
        end

        if (leave) begin
            sec_d = '0;
            case (state_q)
                ALL_RED: begin
                    state_d = GREEN;
                    cur_d   = (cur_q == LAST_DIR) ? '0 : cur_q + 1'b1;
                end
                GREEN:   state_d = YELLOW;
                default: state_d = ALL_RED;
            endcase
        end

        for (int unsigned d = 0; d < NUM_DIRS; d++) begin
            next_mask[d] = (CW'(d) == cur_d);
        end

        // A press by the direction already in green is not a request.
        ignore_mask = (state_q == GREEN) ? cur_mask : '0;
        pending_d   = pending_q | (ped_edge & ~ignore_mask);

        walk_latch_d = walk_latch_q;
        if (leave && (state_q == GREEN)) walk_latch_d = '0;
        // Entering green: the clear of the served request overrides any
        // edge arriving in the same cycle.
        if (leave && (state_d == GREEN)) begin
            walk_latch_d = pending_q & next_mask;
            pending_d    = pending_d & ~next_mask;
        end

        // Lamps are registered from the next state so they track state_q.
        for (int unsigned d = 0; d < NUM_DIRS; d++) begin
            lamp_sel = LAMP_RED;
            if (next_mask[d] && (state_d == GREEN))       lamp_sel = LAMP_GREEN;
            else if (next_mask[d] && (state_d == YELLOW)) lamp_sel = LAMP_YELLOW;
            red_d[d]    = lamp_sel[2];
            yellow_d[d] = lamp_sel[1];
            green_d[d]  = lamp_sel[0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ALL_RED;
            cur_q        <= LAST_DIR;
            sec_q        <= '0;
            blink_q      <= 1'b0;
            pending_q    <= '0;
            walk_latch_q <= '0;
            red_q        <= '1;
            yellow_q     <= '0;
            green_q      <= '0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            sec_q        <= sec_d;
            blink_q      <= blink_d;
            pending_q    <= pending_d;
            walk_latch_q <= walk_latch_d;
            red_q        <= red_d;
            yellow_q     <= yellow_d;
            green_q      <= green_d;
        end
    end

    assign red      = red_q;
    assign yellow   = yellow_q;
    assign green    = green_q;
    assign walk     = green_q & walk_latch_q;
    assign ped_wait = pending_q & {NUM_DIRS{blink_q}};
    assign phase    = cur_q;

endmodule

// File: doc/multi_dir_signal_ctrl.md
# multi_dir_signal_ctrl

Parametrised intersection signal controller for 2 to 8 approach directions. Directions are served round-robin, with each green separated by yellow and all-red clearance. Per-direction pedestrian requests are latched, shown as blinking wait lights, and served with a walk indication during that direction's green. It replaces the fixed two-way controller pair, runs entirely on `clk` with a one-second tick enable (no derived clocks), and sits directly under the board top level.

## Interface
Parameters:
- `NUM_DIRS`, 4: approach count, legal range 2..8.
- `TICK_DIV`, 50_000_000: `clk` cycles per one-second tick, must be ≥ 2.
- `GREEN_S`, 10: green duration in ticks, must be ≥ 1.
- `MIN_GREEN_S`, 3: minimum green before priority truncation, 1 ≤ `MIN_GREEN_S` ≤ `GREEN_S`.
- `YELLOW_S`, 2: yellow duration in ticks, must be ≥ 1.
- `ALL_RED_S`, 1: all-red clearance in ticks, must be ≥ 1.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `ped_req` in `NUM_DIRS`: asynchronous pedestrian buttons, one per direction.
- `red` out `NUM_DIRS`: red lamp per direction.
- `yellow` out `NUM_DIRS`: yellow lamp per direction.
- `green` out `NUM_DIRS`: green lamp per direction.
- `walk` out `NUM_DIRS`: pedestrian walk lamp.
- `ped_wait` out `NUM_DIRS`: blinking wait indicator.
- `phase` out `$clog2(NUM_DIRS)`: index of the direction currently or last served.

## Operation
- FSM states and transitions:
  - ALL_RED → GREEN. Entering GREEN sets `cur` = (`cur`+1) mod `NUM_DIRS`.
  - GREEN → YELLOW.
  - YELLOW → ALL_RED.
- Lamps:
  - Only direction `cur` is non-red, and only in GREEN or YELLOW. All other directions are red.
  - Exactly one of red/yellow/green is high per direction at all times.
- Timer:
  - `sec_cnt` clears on every state entry and increments on each tick.
  - Leave ALL_RED on the tick where `sec_cnt` == `ALL_RED_S`-1.
  - Leave YELLOW on the tick where `sec_cnt` == `YELLOW_S`-1.
  - Leave GREEN on the tick where `sec_cnt` == `GREEN_S`-1.
  - `sec_cnt` width is `$clog2(max(GREEN_S,YELLOW_S,ALL_RED_S)+1)`.
- Tick prescaler:
  - Clears on every state entry, so each state lasts exactly duration×`TICK_DIV` cycles.
  - Wraps at `TICK_DIV`-1 and emits a one-cycle `tick`.
- Pedestrian input:
  - `ped_req[d]` passes through a 2-flop synchroniser, then a rising-edge detector.
  - An edge sets `pending[d]`, except when d == `cur` and the state is GREEN; that edge is ignored.
  - A button held high gives only one request.
- Serving pedestrians:
  - On entry to GREEN for d, `walk_latch[d]` takes the value of `pending[d]`, then `pending[d]` clears. If a set and this clear happen in the same cycle, the clear wins.
  - `walk[d]` = `green[d]` & `walk_latch[d]`. `walk_latch[d]` clears on leaving GREEN.
- Wait indicator:
  - `blink` toggles on every tick.
  - `ped_wait[d]` = `pending[d]` & `blink`.
- `phase` = `cur`.

## Timing
- Reset values:
  - State ALL_RED, `cur` = `NUM_DIRS`-1.
  - `red` all ones. `yellow`, `green`, `walk` and `ped_wait` all zero.
  - `phase` = `NUM_DIRS`-1.
  - `pending`, `blink`, prescaler, `sec_cnt` and synchronisers all zero.
- Lamp outputs are registered and change in the cycle after the transition tick.
- First green goes to direction 0, `ALL_RED_S`×`TICK_DIV` cycles after `rst` deasserts.
- Pedestrian latency: button edge to `pending` set is 3 cycles.
- Reset mid-operation: all lamps drop to reset values immediately (asynchronous), and all pending requests are lost.

## Configuration
- `SIGCTRL_PED_PRIORITY_EN` defined:
  - In GREEN, if any `pending[j]` with j ≠ `cur` is set, GREEN ends on the first tick where `sec_cnt` ≥ `MIN_GREEN_S`-1.
  - Otherwise GREEN runs its normal length.
  - Service order stays round-robin.
- `SIGCTRL_PED_PRIORITY_EN` undefined: GREEN is always exactly `GREEN_S` ticks, and `MIN_GREEN_S` is unused.

## Structure
- Package `sigctrl_pkg`:
  - State enum `sig_state_t` (ALL_RED, GREEN, YELLOW).
  - Lamp encoding constants.
  - A `max3` constant function for the timer width.
- Sub-module `sec_tick_gen`:
  - Parameter `TICK_DIV`; inputs `clk`, `rst`, `clr`; output `tick`.
  - Instantiated once.
- Synchroniser and edge detect are generate loops in the top module.

## Test plan
All scenarios use `NUM_DIRS`=3, `TICK_DIV`=4, `GREEN_S`=5, `MIN_GREEN_S`=2, `YELLOW_S`=2, `ALL_RED_S`=1.
- Reset release:
  - `red`=111 for 4 cycles.
  - Then `green`=001 for 20 cycles, `yellow`=001 for 8, `red`=111 for 4.
  - Then `green`=010 with `phase`=1.
- `ped_req[2]` pulse during dir 0 green, macro off:
  - `ped_wait[2]` toggles every 4 cycles.
  - Dir 0 green stays 20 cycles.
  - `walk[2]`=1 for all 20 cycles of dir 2 green; `ped_wait[2]`=0 from green entry.
- Macro on, `ped_req[1]` edge at second 0 of dir 0 green: yellow starts 8 cycles after green start.
- Macro on, `ped_req[1]` edge at second 3 of dir 0 green: yellow starts at 16 cycles.
- `ped_req[0]` held high during dir 0 green: `pending[0]` stays 0 and no walk is given next cycle.
- `ped_req[1]` held high for 30 cycles: exactly one pending, cleared at dir 1 green.
- `rst` asserted mid-YELLOW: same cycle `red`=111, `yellow`=000, `ped_wait`=000; after release, dir 0 is served first.
